// File: rtl/dac_spi_receiver.sv
// DAC-side serial frame receiver: oversamples sync/sclk/din/ldac_n/clr_n, assembles MSB-first
// frames, decodes the command nibble and maintains the DAC input and output registers.
module dac_spi_receiver #(
   parameter int                FRAME_BITS  = 16,
   parameter int                DATA_W      = 8,
   parameter int                DATA_LSB    = 4,
   parameter logic [DATA_W-1:0] CLR_VALUE   = '0,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sync,
   input  logic              sclk,
   input  logic              din,
   input  logic              ldac_n,
   input  logic              clr_n,
   output logic [DATA_W-1:0] input_reg,
   output logic [DATA_W-1:0] dac_value,
   output logic              frame_valid,
   output logic              frame_err,
   output logic              cmd_err,
   output logic              update,
   output logic              busy
);

   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_BITS);

   localparam int P_SYNC = 0;
   localparam int P_SCLK = 1;
   localparam int P_DIN  = 2;
   localparam int P_LDAC = 3;
   localparam int P_CLR  = 4;

   localparam logic [3:0] CMD_NOP   = 4'b0000;
   localparam logic [3:0] CMD_WRITE = 4'b1000;
   localparam logic [3:0] CMD_WRUPD = 4'b1001;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   logic [4:0]                  pins;
   logic [SYNC_STAGES-1:0][4:0] meta_p0;
   logic [4:0]                  line_p1;
   logic                        sync_prev_p2;
   logic                        sclk_prev_p2;
   logic                        ldac_prev_p2;

   assign pins = {clr_n, ldac_n, din, sclk, sync};

   // Synchronizer chain and edge-history flops; these carry data only, so they are not reset.
   // Because sync history keeps tracking through rst, a sync line already low at release
   // produces no falling edge and the receiver stays unarmed.
   always_ff @(posedge clk) begin
      meta_p0      <= {meta_p0[SYNC_STAGES-2:0], pins};
      sync_prev_p2 <= line_p1[P_SYNC];
      sclk_prev_p2 <= line_p1[P_SCLK];
      ldac_prev_p2 <= line_p1[P_LDAC];
   end

   assign line_p1 = meta_p0[SYNC_STAGES-1];

   logic sync_fall, sync_rise, sclk_fall, ldac_fall, clr_active;

   assign sync_fall  =  sync_prev_p2 & ~line_p1[P_SYNC];
   assign sync_rise  = ~sync_prev_p2 &  line_p1[P_SYNC];
   assign sclk_fall  =  sclk_prev_p2 & ~line_p1[P_SCLK];
   assign ldac_fall  =  ldac_prev_p2 & ~line_p1[P_LDAC];
   assign clr_active = ~line_p1[P_CLR];

   logic [FRAME_BITS-1:0] shift;
   logic [CNT_W-1:0]      count;
   logic                  armed;

   logic                  frame_end;
   logic [3:0]            cmd;
   logic [DATA_W-1:0]     data;

   assign frame_end = sync_rise & armed;
   assign cmd       = shift[FRAME_BITS-1 -: 4];
   assign data      = shift[DATA_LSB +: DATA_W];

   logic [DATA_W-1:0] in_nxt;
   logic [DATA_W-1:0] dac_nxt;
   logic              upd_nxt;
   logic              fv_nxt;
   logic              fe_nxt;
   logic              ce_nxt;

   // ldac transfers the pre-clk input_reg first, a write-and-update frame then
   // overrides it, and an active clear overrides everything except the frame flags.
   always_comb begin
      in_nxt  = input_reg;
      dac_nxt = dac_value;
      upd_nxt = 1'b0;
      fv_nxt  = 1'b0;
      fe_nxt  = 1'b0;
      ce_nxt  = 1'b0;
      if (ldac_fall) begin
         dac_nxt = input_reg;
         upd_nxt = 1'b1;
      end
      if (frame_end) begin
         if (count != FRAME_LEN) begin
            fe_nxt = 1'b1;
         end else begin
            case (cmd)
               CMD_WRITE: begin
                  in_nxt = data;
                  fv_nxt = 1'b1;
               end
               CMD_WRUPD: begin
                  in_nxt  = data;
                  dac_nxt = data;
                  upd_nxt = 1'b1;
                  fv_nxt  = 1'b1;
               end
               CMD_NOP:  fv_nxt = 1'b1;
               default:  ce_nxt = 1'b1;
            endcase
         end
      end
      if (clr_active) begin
         in_nxt  = CLR_VALUE;
         dac_nxt = CLR_VALUE;
         upd_nxt = 1'b0;
      end
   end

   // Frame/register state and registered output pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         input_reg   <= CLR_VALUE;
         dac_value   <= CLR_VALUE;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         cmd_err     <= 1'b0;
         update      <= 1'b0;
         busy        <= 1'b0;
         armed       <= 1'b0;
         count       <= '0;
         shift       <= '0;
      end else begin
         input_reg   <= in_nxt;
         dac_value   <= dac_nxt;
         frame_valid <= fv_nxt;
         frame_err   <= fe_nxt;
         cmd_err     <= ce_nxt;
         update      <= upd_nxt;
         if (sync_fall) begin
            armed <= 1'b1;
            busy  <= 1'b1;
            count <= '0;
         end else if (frame_end) begin
            armed <= 1'b0;
            busy  <= 1'b0;
         end else if (armed && !line_p1[P_SYNC] && sclk_fall) begin
            shift <= {shift[FRAME_BITS-2:0], line_p1[P_DIN]};
            count <= sat_inc(count);
         end
      end
   end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed and randomized frames for dac_spi_receiver, checked against a frame-level reference model.
module tb_dac_spi_receiver;

   localparam logic [7:0] CLR_VALUE = 8'h00;

   logic       clk = 1'b0;
   logic       rst;
   logic       sync;
   logic       sclk;
   logic       din;
   logic       ldac_n;
   logic       clr_n;
   logic [7:0] input_reg;
   logic [7:0] dac_value;
   logic       frame_valid;
   logic       frame_err;
   logic       cmd_err;
   logic       update;
   logic       busy;

   dac_spi_receiver #(
      .FRAME_BITS(16), .DATA_W(8), .DATA_LSB(4), .CLR_VALUE(CLR_VALUE), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst(rst), .sync(sync), .sclk(sclk), .din(din), .ldac_n(ldac_n), .clr_n(clr_n),
      .input_reg(input_reg), .dac_value(dac_value), .frame_valid(frame_valid),
      .frame_err(frame_err), .cmd_err(cmd_err), .update(update), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int hold = 3;

   logic [7:0]  m_in;
   logic [7:0]  m_dac;
   logic [15:0] m_val;
   int          m_cnt;
   bit          m_armed;
   bit          m_clr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, "_input_reg"}, input_reg, m_in);
      chk({tag, "_dac_value"}, dac_value, m_dac);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_n(3);
      rst = 1'b0;
      m_in = CLR_VALUE;
      m_dac = CLR_VALUE;
      m_armed = 0;
      m_cnt = 0;
      wait_n(2);
   endtask

   task automatic frame_begin();
      sync = 1'b0;
      wait_n(hold + 1);
      m_armed = 1;
      m_cnt = 0;
   endtask

   task automatic send_bit(input logic b);
      din = b;
      sclk = 1'b1;
      wait_n(hold);
      sclk = 1'b0;
      wait_n(hold);
      if (m_armed) begin
         m_val = {m_val[14:0], b};
         if (m_cnt < 31) m_cnt++;
      end
   endtask

   // Raise sync (optionally dropping ldac_n on the same clock) and record each
   // output pulse over the following six clocks; all pulses are due on clock 3.
   task automatic frame_end(input bit with_ldac, input string tag);
      logic [6:1] fv, fe, ce, up;
      logic [6:1] e_fv, e_fe, e_ce, e_up;
      logic [7:0] old_in;
      logic [3:0] cmd;
      logic [7:0] data;
      wait_n(2);
      chk({tag, "_busy_in_frame"}, busy, m_armed);
      sync = 1'b1;
      if (with_ldac) ldac_n = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         fv[i] = frame_valid;
         fe[i] = frame_err;
         ce[i] = cmd_err;
         up[i] = update;
      end
      ldac_n = 1'b1;
      e_fv = '0; e_fe = '0; e_ce = '0; e_up = '0;
      old_in = m_in;
      cmd = m_val[15:12];
      data = m_val[11:4];
      if (with_ldac) begin
         m_dac = old_in;
         e_up = 6'b000100;
      end
      if (m_armed) begin
         if (m_cnt != 16) e_fe = 6'b000100;
         else if (cmd == 4'h8) begin m_in = data; e_fv = 6'b000100; end
         else if (cmd == 4'h9) begin m_in = data; m_dac = data; e_fv = 6'b000100; e_up = 6'b000100; end
         else if (cmd == 4'h0) e_fv = 6'b000100;
         else e_ce = 6'b000100;
      end
      if (m_clr) begin
         m_in = CLR_VALUE;
         m_dac = CLR_VALUE;
         e_up = '0;
      end
      m_armed = 0;
      chk({tag, "_frame_valid"}, fv, e_fv);
      chk({tag, "_frame_err"}, fe, e_fe);
      chk({tag, "_cmd_err"}, ce, e_ce);
      chk({tag, "_update"}, up, e_up);
      wait_n(4);
      chk({tag, "_busy_idle"}, busy, 0);
      chk_regs(tag);
   endtask

   task automatic send_frame(input logic [63:0] value, input int nbits, input bit with_ldac,
                             input string tag);
      frame_begin();
      for (int i = nbits - 1; i >= 0; i--) send_bit(value[i]);
      frame_end(with_ldac, tag);
   endtask

   task automatic ldac_pulse(input string tag);
      logic [6:1] up;
      logic [6:1] e_up;
      ldac_n = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         up[i] = update;
      end
      ldac_n = 1'b1;
      if (m_clr) begin
         e_up = '0;
      end else begin
         m_dac = m_in;
         e_up = 6'b000100;
      end
      chk({tag, "_update"}, up, e_up);
      wait_n(4);
      chk_regs(tag);
   endtask

   task automatic set_clr(input logic level);
      clr_n = level;
      m_clr = !level;
      wait_n(5);
      if (m_clr) begin
         m_in = CLR_VALUE;
         m_dac = CLR_VALUE;
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      int          n;
      int          kind;
      logic [3:0]  c;
      bit          wl;

      rst = 1'b1; sync = 1'b1; sclk = 1'b0; din = 1'b0; ldac_n = 1'b1; clr_n = 1'b1;
      m_clr = 0; m_val = '0;
      wait_n(6);
      do_reset();
      chk("reset_input_reg", input_reg, CLR_VALUE);
      chk("reset_dac_value", dac_value, CLR_VALUE);
      chk("reset_flags", {frame_valid, frame_err, cmd_err, update}, 4'b0000);
      chk("reset_busy", busy, 0);

      send_frame(64'h8A50, 16, 0, "t1_write");
      ldac_pulse("t1_ldac");
      send_frame(64'h93C0, 16, 0, "t2_wrupd");
      send_frame(64'hABC, 12, 0, "t3_short");
      send_frame(64'h8A5A5, 20, 0, "t3_long");
      send_frame(64'hF120, 16, 0, "t4_badcmd");
      send_frame(64'h0000, 16, 0, "t4_nop");
      send_frame(64'h8770, 16, 0, "sim_prep");
      send_frame(64'h9120, 16, 1, "sim_wrupd_ldac");
      send_frame(64'h8330, 16, 1, "sim_write_ldac");
      send_frame(64'hFFFF_8123_4567_89A0, 48, 0, "sat_48bit");

      send_frame(64'h9550, 16, 0, "t5_prep");
      set_clr(1'b0);
      chk_regs("t5_clr_level");
      send_frame(64'h8FF0, 16, 0, "t5_clr_frame");
      send_frame(64'h9AB0, 16, 0, "t5_clr_wrupd");
      set_clr(1'b1);
      chk_regs("t5_released");

      send_frame(64'h8550, 16, 0, "t6_prep");
      frame_begin();
      for (int i = 15; i >= 9; i--) send_bit(v[i] ^ v[i]);
      do_reset();
      chk_regs("t6_after_rst");
      for (int i = 0; i < 9; i++) send_bit(1'b1);
      frame_end(0, "t6_discard");
      send_frame(64'h8010, 16, 0, "t6_next");

      for (int k = 0; k < 30; k++) begin
         hold = $urandom_range(3, 5);
         kind = $urandom_range(0, 9);
         v = {$urandom, $urandom};
         n = 16;
         if (kind < 3) v[15:12] = 4'h8;
         else if (kind < 6) v[15:12] = 4'h9;
         else if (kind == 6) v[15:12] = 4'h0;
         else if (kind == 7) begin
            c = 4'h0;
            while (c == 4'h0 || c == 4'h8 || c == 4'h9) c = 4'($urandom_range(0, 15));
            v[15:12] = c;
         end else begin
            n = $urandom_range(1, 23);
            if (n == 16) n = 17;
         end
         wl = ($urandom_range(0, 3) == 0);
         send_frame(v, n, wl, "rand_frame");
         if ($urandom_range(0, 2) == 0) ldac_pulse("rand_ldac");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
